// File: rtl/tone_pkg.sv
// Shared definitions for the tone gate and its helpers.
//   tone_state_e : gate FSM states
//   *_DEF        : default clock rate and field widths
//   ms_div()     : clocks per millisecond for a given clock rate
package tone_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned DUR_W_DEF  = 16;
  localparam int unsigned VOL_W_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EDGE = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } tone_state_e;

  function automatic int unsigned ms_div(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..DIV-1 while enabled and pulses tick_c
// in the cycle the count is at DIV-1 (the count wraps on that edge).
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : count enable
//   tick_c   : one-cycle tick, combinational from the count register
module ms_tick_gen
  import tone_pkg::*;
#(
  parameter int unsigned DIV = ms_div(CLK_HZ_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count and tick
  always_comb begin
    cnt_d  = cnt_q;
    tick_c = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tone_gate.sv
// Gates a square-wave tone into a PWM-volume speaker drive for a requested
// number of milliseconds, starting on a tone rising edge and stopping on a
// falling edge so no half-period is truncated.
//   clk, rst          : clock, async active-high reset
//   tone_in           : raw square wave from the tone generator
//   req_valid/ready   : request handshake (ready only while idle)
//   req_dur_ms        : note length in ms (0 = complete immediately)
//   req_vol           : PWM volume, 0 silent, all-ones full
//   stop              : synchronous abort
//   spk_out           : gated speaker drive
//   busy              : note in progress
//   done              : one-cycle completion pulse
module tone_gate
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF,
  parameter int unsigned DUR_W  = DUR_W_DEF,
  parameter int unsigned VOL_W  = VOL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DUR_W-1:0] req_dur_ms,
  input  logic [VOL_W-1:0] req_vol,
  input  logic             stop,
  output logic             spk_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      MS_DIV   = ms_div(CLK_HZ);
  localparam logic [VOL_W-1:0] VOL_FULL = '1;

  tone_state_e      state_q, state_d;
  logic             tone_q;
  logic [VOL_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             spk_q, spk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic rise_c, fall_c, pwm_on_c, tick_c, presc_clr_c, presc_en_c;

  // Tone edges relative to the registered copy
  assign rise_c = tone_in & ~tone_q;
  assign fall_c = ~tone_in & tone_q;

  // Full scale bypasses the compare so volume all-ones is a solid tone
  assign pwm_on_c  = (vol_q == VOL_FULL) | (pwm_cnt_q < vol_q);
  assign pwm_cnt_d = pwm_cnt_q + VOL_W'(1);

  ms_tick_gen #(
    .DIV (MS_DIV)
  ) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (presc_clr_c),
    .en     (presc_en_c),
    .tick_c (tick_c)
  );

  // Next state, datapath and registered outputs
  always_comb begin
    state_d     = state_q;
    dur_d       = dur_q;
    vol_d       = vol_q;
    rem_d       = rem_q;
    spk_d       = 1'b0;
    presc_clr_c = 1'b0;
    presc_en_c  = (state_q == ST_PLAY);

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          dur_d   = req_dur_ms;
          vol_d   = req_vol;
          state_d = (req_dur_ms == '0) ? ST_DONE : ST_WAIT_EDGE;
        end
      end
      ST_WAIT_EDGE: begin
        // stop first: the tone may be stuck and never produce a rise
        if (stop) begin
          state_d = ST_DONE;
        end else if (rise_c) begin
          state_d     = ST_PLAY;
          presc_clr_c = 1'b1;
          rem_d       = dur_q;
        end
      end
      ST_PLAY: begin
        spk_d = tone_q & pwm_on_c;
        if (tick_c) rem_d = rem_q - DUR_W'(1);
        if (stop || (tick_c && (rem_q == DUR_W'(1)))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // finish the current high half, cut exactly at the falling edge
        if (fall_c) state_d = ST_DONE;
        else        spk_d   = tone_q & pwm_on_c;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_WAIT_EDGE) || (state_d == ST_PLAY) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tone_q    <= 1'b0;
      pwm_cnt_q <= '0;
      dur_q     <= '0;
      vol_q     <= '0;
      rem_q     <= '0;
      spk_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tone_q    <= tone_in;
      pwm_cnt_q <= pwm_cnt_d;
      dur_q     <= dur_d;
      vol_q     <= vol_d;
      rem_q     <= rem_d;
      spk_q     <= spk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign spk_out   = spk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_ready = ready_q;

endmodule
